// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter for two byte requesters, feeding a serial transmitter through a one-byte hold register.
// Grant 1 cycle after request; issue 1 cycle after tx_ready_i with hold full; requesters stall while hold is full.
module tx_frame_arbiter #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  rq_valid_i,
  input  logic [15:0] rq_data_i,
  input  logic [1:0]  rq_last_i,
  output logic [1:0]  rq_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_packet_o,
  input  logic        tx_ready_i,
  output logic        tx_reset_o,
  output logic [1:0]  grant_o,
  output logic        done_o,
  output logic        abort_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_READY, S_WAIT_ACCEPT, S_RECOVER} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  grant_q;
  logic        last_grant_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        hold_last_q;
  logic        last_taken_q;
  logic        in_frame_q;
  logic        sent_last_q;
  logic [15:0] tmo_q;
  logic        rec_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        tx_packet_q;
  logic        tx_reset_q;
  logic        done_q;
  logic        abort_q;

  logic       gidx;
  logic       take;
  logic [7:0] take_dat;
  logic       take_last;
  logic       tmo_hit;
  logic       rec_req;

  assign gidx       = grant_q[1];
  assign rq_ready_o = grant_q & {2{~hold_vld_q & ~last_taken_q}};
  assign take       = |(rq_valid_i & rq_ready_o);
  assign take_dat   = gidx ? rq_data_i[15:8] : rq_data_i[7:0];
  assign take_last  = gidx ? rq_last_i[1] : rq_last_i[0];
  assign tmo_hit    = (tmo_q >= TMO_LAST);

  // Recovery: ACK seen with nothing prefetched (underflow), or a wait state ran out of time.
  always_comb begin
    rec_req = 1'b0;
    case (state_q)
      S_WAIT_READY:  rec_req = !(tx_ready_i && hold_vld_q) && !(tx_ready_i && sent_last_q)
                               && ((tx_ready_i && in_frame_q) || tmo_hit);
      S_WAIT_ACCEPT: rec_req = tx_ready_i && tmo_hit;
      default:       rec_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
      hold_last_q  <= 1'b0;
      last_taken_q <= 1'b0;
      in_frame_q   <= 1'b0;
      sent_last_q  <= 1'b0;
      tmo_q        <= 16'd0;
      rec_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_packet_q  <= 1'b0;
      tx_reset_q   <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;

      if (take) begin
        hold_q       <= take_dat;
        hold_vld_q   <= 1'b1;
        hold_last_q  <= take_last;
        last_taken_q <= take_last;
      end

      if (rec_req) begin
        state_q      <= S_RECOVER;
        rec_q        <= 1'b0;
        tmo_q        <= 16'd0;
        tx_reset_q   <= 1'b1;
        abort_q      <= 1'b1;
        tx_packet_q  <= 1'b0;
        last_grant_q <= gidx;
        grant_q      <= 2'b00;
        hold_vld_q   <= 1'b0;
        last_taken_q <= 1'b0;
        in_frame_q   <= 1'b0;
        sent_last_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            in_frame_q  <= 1'b0;
            sent_last_q <= 1'b0;
            tmo_q       <= 16'd0;
            if (|rq_valid_i) begin
              if (rq_valid_i[0] && (!rq_valid_i[1] || last_grant_q)) grant_q <= 2'b01;
              else                                                    grant_q <= 2'b10;
              state_q <= S_WAIT_READY;
            end
          end
          S_WAIT_READY: begin
            if (tx_ready_i && hold_vld_q) begin
              tx_valid_q  <= 1'b1;
              tx_data_q   <= hold_q;
              tx_packet_q <= ~hold_last_q;
              hold_vld_q  <= 1'b0;
              in_frame_q  <= 1'b1;
              sent_last_q <= hold_last_q;
              tmo_q       <= 16'd0;
              state_q     <= S_WAIT_ACCEPT;
            end else if (tx_ready_i && sent_last_q) begin
              done_q       <= 1'b1;
              last_grant_q <= gidx;
              grant_q      <= 2'b00;
              tx_packet_q  <= 1'b0;
              last_taken_q <= 1'b0;
              tmo_q        <= 16'd0;
              state_q      <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          S_WAIT_ACCEPT: begin
            if (!tx_ready_i) begin
              tmo_q   <= 16'd0;
              state_q <= S_WAIT_READY;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          S_RECOVER: begin
            // tx_reset was raised on entry; hold it one more cycle.
            if (!rec_q) begin
              rec_q <= 1'b1;
            end else begin
              tx_reset_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign tx_packet_o = tx_packet_q;
  assign tx_reset_o  = tx_reset_q;
  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;

endmodule
